// File: rtl/ili9341_pkg.sv
// ---------------------------------------------------------------------------
// ili9341_pkg
//   Shared types and constants for the ILI9341 byte scheduler.
//   - sched_state_t : scheduler FSM states
//   - DC_CMD/DC_DATA: D/C pin levels (0 = command, 1 = data)
//   - BYTE_W/ENTRY_W: payload width and FIFO entry width ({dc, data})
// ---------------------------------------------------------------------------
package ili9341_pkg;

    localparam int   BYTE_W  = 8;
    localparam int   ENTRY_W = BYTE_W + 1;
    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SEND,
        WAIT,
        HOLD
    } sched_state_t;

    // FIFO entries are packed as {dc, data}; the top bit carries the D/C level.
    function automatic logic entry_is_data(input logic [ENTRY_W-1:0] e);
        return e[BYTE_W] == DC_DATA;
    endfunction

endpackage

// File: rtl/spi_byte_fifo.sv
// ---------------------------------------------------------------------------
// spi_byte_fifo
//   Synchronous FIFO holding {dc, data} entries for the byte scheduler.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//     push, wr_data write request (ignored when full)
//     pop, rd_data  read request (ignored when empty); rd_data shows the head
//     full, empty   status derived from the registered level
//     level         entries currently stored
//   Pointers wrap modulo DEPTH (power of two); the level is kept in its own
//   counter so full is simply level == DEPTH.
// ---------------------------------------------------------------------------
module spi_byte_fifo
    import ili9341_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = ENTRY_W,
    parameter int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    // full is based on the registered level, so a push offered while full is
    // refused even if a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/ili9341_byte_sched.sv
// ---------------------------------------------------------------------------
// ili9341_byte_sched
//   Buffers command/data bytes for an ILI9341 panel and hands them one at a
//   time to the SPI shift controller, framing each transfer with lcd_cs_n and
//   setup/hold gaps.
//   Ports:
//     clk, rst                 clock, asynchronous active-high reset
//     in_valid/in_ready        upstream handshake (in_ready = FIFO not full)
//     in_data, in_dc           byte and its D/C level (0 = cmd, 1 = data)
//     spi_send                 one-cycle start pulse to the SPI controller
//     spi_done                 one-cycle completion pulse (ignored unless waiting)
//     tx_byte, lcd_dc          byte + D/C, latched at pop, held until next pop
//     lcd_cs_n                 panel chip select, active low
//     busy                     FSM active or bytes pending
//     timeout_err              sticky, set when spi_done never arrives
//     fifo_level               entries buffered
//   Build option: define ILI9341_CS_BURST_EN to keep CS low across back-to-back
//   bytes (HOLD goes straight to SEND when the FIFO has more data). Without it
//   every byte gets its own CS frame.
// ---------------------------------------------------------------------------
module ili9341_byte_sched
    import ili9341_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [BYTE_W-1:0]                 in_data,
    input  logic                              in_dc,
    output logic                              spi_send,
    input  logic                              spi_done,
    output logic [BYTE_W-1:0]                 tx_byte,
    output logic                              lcd_dc,
    output logic                              lcd_cs_n,
    output logic                              busy,
    output logic                              timeout_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    // One down-counter serves setup, wait and hold; size it for the largest load.
    localparam int CNT_MAX = (TIMEOUT > CS_SETUP)
                           ? ((TIMEOUT > CS_HOLD) ? TIMEOUT : CS_HOLD)
                           : ((CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD);
    localparam int CW = $clog2(CNT_MAX);

    sched_state_t        state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                send_q, send_d;
    logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
    logic                lcd_dc_q, lcd_dc_d;
    logic                cs_n_q, cs_n_d;
    logic                timeout_err_q, timeout_err_d;

    logic                fifo_pop, fifo_full, fifo_empty;
    logic [ENTRY_W-1:0]  fifo_rd;

    spi_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (in_valid),
        .wr_data ({in_dc, in_data}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_comb begin
        state_d       = state_q;
        // Saturating decrement: the counter parks at zero.
        cnt_d         = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        send_d        = 1'b0;
        tx_byte_d     = tx_byte_q;
        lcd_dc_d      = lcd_dc_q;
        cs_n_d        = cs_n_q;
        timeout_err_d = timeout_err_q;
        fifo_pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    cnt_d   = CW'(CS_SETUP - 1);
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    fifo_pop  = 1'b1;
                    tx_byte_d = fifo_rd[BYTE_W-1:0];
                    lcd_dc_d  = entry_is_data(fifo_rd) ? DC_DATA : DC_CMD;
                    send_d    = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                state_d = WAIT;
                cnt_d   = CW'(TIMEOUT - 1);
            end
            WAIT: begin
                if (spi_done || cnt_q == '0) begin
                    if (!spi_done) timeout_err_d = 1'b1;
                    state_d = HOLD;
                    cnt_d   = CW'(CS_HOLD - 1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
`ifdef ILI9341_CS_BURST_EN
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        tx_byte_d = fifo_rd[BYTE_W-1:0];
                        lcd_dc_d  = entry_is_data(fifo_rd) ? DC_DATA : DC_CMD;
                        send_d    = 1'b1;
                        state_d   = SEND;
                    end else begin
                        cs_n_d  = 1'b1;
                        state_d = IDLE;
                    end
`else
                    cs_n_d  = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            send_q        <= 1'b0;
            tx_byte_q     <= '0;
            lcd_dc_q      <= DC_CMD;
            cs_n_q        <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            send_q        <= send_d;
            tx_byte_q     <= tx_byte_d;
            lcd_dc_q      <= lcd_dc_d;
            cs_n_q        <= cs_n_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign in_ready    = ~fifo_full;
    assign spi_send    = send_q;
    assign tx_byte     = tx_byte_q;
    assign lcd_dc      = lcd_dc_q;
    assign lcd_cs_n    = cs_n_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_ili9341_byte_sched.sv
// ---------------------------------------------------------------------------
// tb_ili9341_byte_sched
//   Directed bench for ili9341_byte_sched. A queue model holds the bytes the
//   upstream side has handed over; every spi_send must present the queue head
//   on tx_byte/lcd_dc, and fifo_level/in_ready/busy must agree with the queue.
//   Hand-computed latency/timeout points pin the model. An SPI responder
//   answers each send with spi_done after resp_delay cycles unless disabled.
// ---------------------------------------------------------------------------
module tb_ili9341_byte_sched;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_dc = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       resp_done = 1'b0;
    logic       stray_done = 1'b0;
    logic       spi_done;
    logic       in_ready, spi_send, lcd_dc, lcd_cs_n, busy, timeout_err;
    logic [7:0] tx_byte;
    logic [4:0] fifo_level;

    assign spi_done = resp_done | stray_done;

    ili9341_byte_sched dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_dc       (in_dc),
        .spi_send    (spi_send),
        .spi_done    (spi_done),
        .tx_byte     (tx_byte),
        .lcd_dc      (lcd_dc),
        .lcd_cs_n    (lcd_cs_n),
        .busy        (busy),
        .timeout_err (timeout_err),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [8:0] mq[$];
    logic [8:0] last_tx = 9'h000;
    logic       prev_send = 1'b0;
    logic       prev_cs = 1'b1;
    int         cs_falls = 0;
    int         resp_delay = 18;
    bit         resp_en = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s actual=timeout expected=event t=%0t", name, $time);
    endtask

    // Model: upstream transfers enter the queue when the queue has room.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) mq.delete();
        else if (in_valid && mq.size() < DEPTH) mq.push_back({in_dc, in_data});
    end

    // Compare process: runs every falling edge, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            last_tx   = 9'h000;
            prev_send = 1'b0;
            prev_cs   = 1'b1;
        end else begin
            if (spi_send) begin
                chk("send_cs_low", lcd_cs_n, 0);
                chk("send_not_held", prev_send, 0);
                chk("send_has_byte", mq.size() != 0, 1);
                if (mq.size() != 0) last_tx = mq.pop_front();
            end
            chk("tx_dc_value", {lcd_dc, tx_byte}, last_tx);
            chk("fifo_level", fifo_level, mq.size());
            chk("in_ready", in_ready, mq.size() < DEPTH);
            if (mq.size() != 0 || !lcd_cs_n) chk("busy", busy, 1);
            if (prev_cs && !lcd_cs_n) cs_falls++;
            prev_send = spi_send;
            prev_cs   = lcd_cs_n;
        end
    end

    // SPI controller stand-in: answer each send with a done pulse.
    initial forever begin
        @(negedge clk);
        if (spi_send && resp_en && !rst) begin
            repeat (resp_delay - 1) @(negedge clk);
            resp_done = 1'b1;
            @(negedge clk);
            resp_done = 1'b0;
        end
    end

    task automatic push(input logic [8:0] v);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        {in_dc, in_data} = v;
        for (int t = 0; t < 2000 && !acc; t++) begin
            acc = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!acc) bound_fail("push_accept");
    endtask

    task automatic wait_send(input string name);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (spi_send) return;
        end
        bound_fail(name);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (!busy && lcd_cs_n && mq.size() == 0) return;
            @(negedge clk);
        end
        bound_fail(name);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_frames;
`ifdef ILI9341_CS_BURST_EN
        exp_frames = 1;
`else
        exp_frames = 4;
`endif
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_send", spi_send, 0);
        chk("rst_tx", tx_byte, 0);
        chk("rst_dc", lcd_dc, 0);
        chk("rst_cs", lcd_cs_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // Single byte: push accepted at edge N
        resp_delay = 18;
        in_valid = 1'b1;
        {in_dc, in_data} = {1'b0, 8'h2A};
        @(negedge clk);
        in_valid = 1'b0;
        chk("t2_cs_N", lcd_cs_n, 1);
        chk("t2_level_N", fifo_level, 1);
        @(negedge clk);
        chk("t2_cs_N1", lcd_cs_n, 0);
        chk("t2_send_N1", spi_send, 0);
        @(negedge clk);
        chk("t2_send_N2", spi_send, 0);
        @(negedge clk);
        chk("t2_send_N3", spi_send, 1);
        chk("t2_tx_N3", tx_byte, 8'h2A);
        chk("t2_dc_N3", lcd_dc, 0);
        chk("t2_level_N3", fifo_level, 0);
        repeat (19) @(negedge clk);
        chk("t2_cs_hold", lcd_cs_n, 0);
        @(negedge clk);
        chk("t2_cs_release", lcd_cs_n, 1);
        chk("t2_busy_end", busy, 0);
        wait_idle("t2_idle");

        // Stray done in IDLE and in SETUP
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_cs", lcd_cs_n, 1);
        in_valid = 1'b1;
        {in_dc, in_data} = {1'b1, 8'h77};
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        chk("t6_setup_level", fifo_level, 1);
        chk("t6_setup_send", spi_send, 0);
        @(negedge clk);
        chk("t6_send", spi_send, 1);
        chk("t6_tx", tx_byte, 8'h77);
        chk("t6_dc", lcd_dc, 1);
        wait_idle("t6_idle");

        // Fill while the first byte is in flight
        resp_delay = 40;
        push({1'b0, 8'h11});
        wait_send("t3_first_send");
        for (int i = 0; i < 16; i++) push({1'b1, 8'h80 + 8'(i)});
        chk("t3_level_full", fifo_level, 16);
        chk("t3_ready_full", in_ready, 0);
        resp_delay = 3;
        in_valid = 1'b1;
        {in_dc, in_data} = {1'b1, 8'hEE};
        @(negedge clk);
        chk("t3_stall_level", fifo_level, 16);
        push({1'b1, 8'hEE});
        wait_idle("t3_idle");

        // Command + 3 data bytes
        cs_falls = 0;
        push({1'b0, 8'h2C});
        push({1'b1, 8'h01});
        push({1'b1, 8'h02});
        push({1'b1, 8'h03});
        wait_idle("t4_idle");
        chk("t4_cs_frames", cs_falls, exp_frames);

        // Timeout: no done for the first byte
        resp_en = 1'b0;
        push({1'b0, 8'h55});
        push({1'b1, 8'h66});
        wait_send("t5_send");
        repeat (64) @(negedge clk);
        chk("t5_terr_before", timeout_err, 0);
        @(negedge clk);
        chk("t5_terr_set", timeout_err, 1);
        resp_en = 1'b1;
        wait_idle("t5_idle");
        chk("t5_terr_sticky", timeout_err, 1);

        // Reset mid-WAIT with bytes still queued
        resp_delay = 30;
        push({1'b0, 8'hA1});
        push({1'b1, 8'hA2});
        push({1'b1, 8'hA3});
        wait_send("t1_send");
        repeat (3) @(negedge clk);
        chk("t1_level_pre", fifo_level, 2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t1_cs", lcd_cs_n, 1);
        chk("t1_send", spi_send, 0);
        chk("t1_level", fifo_level, 0);
        chk("t1_terr", timeout_err, 0);
        chk("t1_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("t1_after_busy", busy, 0);
        chk("t1_after_cs", lcd_cs_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
